// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - two-voice 8-step score player with per-step articulation gap
module note_sequencer #(
  parameter int TICKS_PER_STEP = 3_000_000,
  parameter int GAP_CYCLES     = 120_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        loop_ena,
  output logic [11:0] channel1_pitch,
  output logic [11:0] channel2_pitch,
  output logic        channel1_ena,
  output logic        channel2_ena,
  output logic        playing,
  output logic [2:0]  step_idx
);

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] NOTE_LAST = CW'(TICKS_PER_STEP - GAP_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    r_step;
  logic [2:0]    w_step_nx;
  logic          r_ss_q;
  logic          w_rise;
  logic [11:0]   w_rom1;
  logic [11:0]   w_rom2;
  logic [11:0]   w_p1_nx;
  logic [11:0]   w_p2_nx;
  logic          w_e1_nx;
  logic          w_e2_nx;
  logic          w_play_nx;

  assign w_rise = start_stop & ~r_ss_q;

  // Score ROM lookup for the step that will be sounding next cycle
  always_comb begin
    w_rom1 = 12'd0;
    w_rom2 = 12'd0;
    case (w_step_nx)
      3'd0: begin w_rom1 = 12'd178; w_rom2 = 12'd44; end
      3'd1: begin w_rom1 = 12'd178; w_rom2 = 12'd52; end
      3'd2: begin w_rom1 = 12'd0;   w_rom2 = 12'd35; end
      3'd3: begin w_rom1 = 12'd178; w_rom2 = 12'd44; end
      3'd4: begin w_rom1 = 12'd0;   w_rom2 = 12'd0;  end
      3'd5: begin w_rom1 = 12'd52;  w_rom2 = 12'd35; end
      3'd6: begin w_rom1 = 12'd178; w_rom2 = 12'd0;  end
      default: begin w_rom1 = 12'd0; w_rom2 = 12'd44; end
    endcase
  end

  // Next state, step and tick count; a start/stop rise always wins over stepping
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nx = S_NOTE;
          w_step_nx  = 3'd0;
          w_cnt_nx   = '0;
        end
      end
      S_NOTE: begin
        if (w_rise) begin
          w_state_nx = S_IDLE;
          w_step_nx  = 3'd0;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          if (r_cnt == NOTE_LAST) begin
            w_state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_rise) begin
          w_state_nx = S_IDLE;
          w_step_nx  = 3'd0;
          w_cnt_nx   = '0;
        end else if (r_cnt == STEP_LAST) begin
          w_cnt_nx = '0;
          if (r_step != 3'd7) begin
            w_state_nx = S_NOTE;
            w_step_nx  = r_step + 3'd1;
          end else if (loop_ena) begin
            w_state_nx = S_NOTE;
            w_step_nx  = 3'd0;
          end else begin
            w_state_nx = S_IDLE;
            w_step_nx  = 3'd0;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_step_nx  = 3'd0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Output values derived from the upcoming state so the ports can be registered
  always_comb begin
    w_play_nx = (w_state_nx != S_IDLE);
    w_p1_nx   = w_play_nx ? w_rom1 : 12'd0;
    w_p2_nx   = w_play_nx ? w_rom2 : 12'd0;
    w_e1_nx   = (w_state_nx == S_NOTE) && (w_rom1 != 12'd0);
    w_e2_nx   = (w_state_nx == S_NOTE) && (w_rom2 != 12'd0);
  end

  // State, counter, edge-detect and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_step         <= 3'd0;
      r_ss_q         <= 1'b1;
      channel1_pitch <= 12'd0;
      channel2_pitch <= 12'd0;
      channel1_ena   <= 1'b0;
      channel2_ena   <= 1'b0;
      playing        <= 1'b0;
      step_idx       <= 3'd0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_step         <= w_step_nx;
      r_ss_q         <= start_stop;
      channel1_pitch <= w_p1_nx;
      channel2_pitch <= w_p2_nx;
      channel1_ena   <= w_e1_nx;
      channel2_ena   <= w_e2_nx;
      playing        <= w_play_nx;
      step_idx       <= w_step_nx;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;
  localparam int T = 10;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        loop_ena = 1'b0;
  logic [11:0] p1, p2;
  logic        e1, e2, pl;
  logic [2:0]  si;

  note_sequencer #(.TICKS_PER_STEP(T), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .loop_ena(loop_ena),
    .channel1_pitch(p1), .channel2_pitch(p2),
    .channel1_ena(e1), .channel2_ena(e2),
    .playing(pl), .step_idx(si)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int rom1 [8] = '{178, 178, 0, 178, 0, 52, 178, 0};
  int rom2 [8] = '{44, 52, 35, 44, 0, 35, 0, 44};

  // Reference: playback is "elapsed cycles since step 0 began"
  bit m_prev = 1'b1;
  bit m_play = 1'b0;
  int m_el   = 0;

  typedef struct {
    int off;
    int p1, p2, e1, e2, st, pl;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit l);
    bit rise;
    if (r) begin
      m_play = 1'b0;
      m_el   = 0;
      m_prev = 1'b1;
    end else begin
      rise   = s & ~m_prev;
      m_prev = s;
      if (m_play) begin
        if (rise) begin
          m_play = 1'b0;
        end else begin
          m_el++;
          if (m_el == 8 * T) begin
            if (l) m_el = 0;
            else   m_play = 1'b0;
          end
        end
      end else if (rise) begin
        m_play = 1'b1;
        m_el   = 0;
      end
    end
  endtask

  task automatic check_model();
    int st, pos, x1, x2, xe1, xe2;
    st = 0; x1 = 0; x2 = 0; xe1 = 0; xe2 = 0;
    if (m_play) begin
      st  = m_el / T;
      pos = m_el % T;
      x1  = rom1[st];
      x2  = rom2[st];
      xe1 = (x1 != 0 && pos < T - G) ? 1 : 0;
      xe2 = (x2 != 0 && pos < T - G) ? 1 : 0;
    end
    chk("model_pitch1", p1, x1);
    chk("model_pitch2", p2, x2);
    chk("model_ena1", e1, xe1);
    chk("model_ena2", e2, xe2);
    chk("model_playing", pl, m_play);
    chk("model_step", si, st);
  endtask

  task automatic cyc(input bit r, input bit s, input bit l);
    rst = r; start_stop = s; loop_ena = l;
    @(posedge clk);
    model_step(r, s, l);
    #1;
    check_model();
  endtask

  initial begin
    int k;
    bit s_r, l_r;
    tbl[0]  = '{0,  178, 44, 1, 1, 0, 1};
    tbl[1]  = '{7,  178, 44, 1, 1, 0, 1};
    tbl[2]  = '{8,  178, 44, 0, 0, 0, 1};
    tbl[3]  = '{9,  178, 44, 0, 0, 0, 1};
    tbl[4]  = '{10, 178, 52, 1, 1, 1, 1};
    tbl[5]  = '{20, 0,   35, 0, 1, 2, 1};
    tbl[6]  = '{27, 0,   35, 0, 1, 2, 1};
    tbl[7]  = '{28, 0,   35, 0, 0, 2, 1};
    tbl[8]  = '{40, 0,   0,  0, 0, 4, 1};
    tbl[9]  = '{50, 52,  35, 1, 1, 5, 1};
    tbl[10] = '{60, 178, 0,  1, 0, 6, 1};
    tbl[11] = '{70, 0,   44, 0, 1, 7, 1};
    tbl[12] = '{79, 0,   44, 0, 0, 7, 1};
    tbl[13] = '{80, 0,   0,  0, 0, 0, 0};

    // 1: button held through reset must not start playback
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    chk("reset_playing", pl, 0);
    chk("reset_pitch1", p1, 0);
    chk("reset_ena2", e2, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("held_no_play", pl, 0);

    // 2: single pass, table of expected outputs at offsets from start
    k = 0;
    cyc(0, 1, 0);
    for (int off = 0; off <= 80; off++) begin
      if (off > 0) cyc(0, 0, 0);
      if (k < 14 && tbl[k].off == off) begin
        chk($sformatf("tbl%0d_p1", off), p1, tbl[k].p1);
        chk($sformatf("tbl%0d_p2", off), p2, tbl[k].p2);
        chk($sformatf("tbl%0d_e1", off), e1, tbl[k].e1);
        chk($sformatf("tbl%0d_e2", off), e2, tbl[k].e2);
        chk($sformatf("tbl%0d_step", off), si, tbl[k].st);
        chk($sformatf("tbl%0d_play", off), pl, tbl[k].pl);
        k++;
      end
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);

    // 3: looping wraps step 7 back to step 0 without leaving play
    cyc(0, 1, 1);
    for (int off = 1; off < 80; off++) cyc(0, 0, 1);
    chk("loop_last_p2", p2, 44);
    cyc(0, 0, 1);
    chk("loop_wrap_step", si, 0);
    chk("loop_wrap_p1", p1, 178);
    chk("loop_wrap_play", pl, 1);
    for (int i = 0; i < 90; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("loop_stop", pl, 0);
    cyc(0, 0, 0);

    // 4: stop at counter 4 of step 3, restart goes to step 0
    cyc(0, 1, 0);
    for (int off = 1; off <= 34; off++) cyc(0, 0, 0);
    chk("t4_before_step", si, 3);
    cyc(0, 1, 0);
    chk("t4_stop_play", pl, 0);
    chk("t4_stop_p1", p1, 0);
    chk("t4_stop_e2", e2, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t4_restart_step", si, 0);
    chk("t4_restart_p1", p1, 178);

    // 5: stop coincident with the last gap cycle of step 5
    for (int off = 1; off <= 59; off++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t5_idle", pl, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0);
      chk("t5_no_step6", (si == 3'd6), 0);
    end

    // 6: reset during gap of step 6, no resume without a fresh rise
    cyc(0, 1, 0);
    for (int off = 1; off <= 68; off++) cyc(0, 0, 0);
    chk("t6_in_gap_step", si, 6);
    cyc(1, 0, 0);
    chk("t6_reset_play", pl, 0);
    chk("t6_reset_p1", p1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    chk("t6_still_idle", pl, 0);
    cyc(0, 1, 0);
    chk("t6_fresh_start", pl, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Randomized run against the reference model
    s_r = 1'b0;
    l_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) s_r = ~s_r;
      if ($urandom_range(0, 99) == 0) l_r = ~l_r;
      cyc(($urandom_range(0, 299) == 0), s_r, l_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
